// File: rtl/pipelined_datapath_if.sv
// Issue/result bus between the control sequencer (master) and pipelined_datapath (slave).
// Carries the issue handshake, operand/immediate selects, write-back controls and EX-stage results.
interface pipelined_datapath_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             hold;
  logic [SEL_W-1:0] dest_sel;
  logic [SEL_W-1:0] a_sel;
  logic [SEL_W-1:0] b_sel;
  logic [3:0]       op_sel;
  logic [WIDTH-1:0] const_in;
  logic             const_sel;
  logic [WIDTH-1:0] data_in;
  logic             data_sel;
  logic             load_en;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] around;
  logic [WIDTH-1:0] res_out;
  logic             out_valid;
  logic             flag_z;
  logic             flag_c;
  logic             flag_n;

  modport master (
    output in_valid, hold, dest_sel, a_sel, b_sel, op_sel, const_in, const_sel,
           data_in, data_sel, load_en,
    input  in_ready, a_out, b_out, around, res_out, out_valid, flag_z, flag_c, flag_n
  );

  modport slave (
    input  in_valid, hold, dest_sel, a_sel, b_sel, op_sel, const_in, const_sel,
           data_in, data_sel, load_en,
    output in_ready, a_out, b_out, around, res_out, out_valid, flag_z, flag_c, flag_n
  );
endinterface

// File: rtl/pipelined_datapath.sv
// Two-stage datapath (IS: regfile read + operand mux, EX: FU, flags, write-back).
// Optional macro FORWARD_EN: forward the EX result to IS; otherwise stall one cycle on a RAW hazard.
module pipelined_datapath #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4,
  parameter int OP_W  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_datapath_if.slave bus
);
  localparam int NREGS = 2 ** SEL_W;

  logic [WIDTH-1:0] r_regs [NREGS];

  logic             r_ex_valid;
  logic             r_load_en;
  logic             r_data_sel;
  logic [SEL_W-1:0] r_dest;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_bp;
  logic [WIDTH-1:0] r_data;
  logic             r_flag_z;
  logic             r_flag_c;
  logic             r_flag_n;

  logic [WIDTH-1:0] w_fu;
  logic             w_fu_c;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             w_ex_wr;
  logic             w_hazard;
  logic             w_ready;
  logic             w_fire;

  // Handshake: an op transfers on a rising edge where in_valid && in_ready;
  // in_valid may be raised regardless of in_ready, and in_ready never depends on in_valid.
  assign w_ex_wr = r_ex_valid & r_load_en;
  assign w_ready = ~bus.hold & ~w_hazard;
  assign w_fire  = bus.in_valid & w_ready;

`ifdef FORWARD_EN
  assign w_hazard = 1'b0;
  assign w_rd_a   = (w_ex_wr && (r_dest == bus.a_sel)) ? w_res : r_regs[bus.a_sel];
  assign w_rd_b   = (w_ex_wr && (r_dest == bus.b_sel)) ? w_res : r_regs[bus.b_sel];
`else
  // b_sel is compared even for immediate ops; keeps the hazard term independent of const_sel.
  assign w_hazard = w_ex_wr & ((r_dest == bus.a_sel) | (r_dest == bus.b_sel));
  assign w_rd_a   = r_regs[bus.a_sel];
  assign w_rd_b   = r_regs[bus.b_sel];
`endif

  always_comb begin
    w_fu   = '0;
    w_fu_c = 1'b0;
    case (r_op)
      4'd0:  w_fu = r_a;
      4'd1:  w_fu = r_bp;
      4'd2:  {w_fu_c, w_fu} = {1'b0, r_a} + {1'b0, r_bp};
      4'd3:  {w_fu_c, w_fu} = {1'b0, r_a} - {1'b0, r_bp};
      4'd4:  w_fu = r_a & r_bp;
      4'd5:  w_fu = r_a | r_bp;
      4'd6:  w_fu = r_a ^ r_bp;
      4'd7:  w_fu = ~r_a;
      4'd8:  {w_fu_c, w_fu} = {1'b0, r_a} + (WIDTH+1)'(1);
      4'd9:  {w_fu_c, w_fu} = {1'b0, r_a} - (WIDTH+1)'(1);
      4'd10: {w_fu_c, w_fu} = {r_a, 1'b0};
      4'd11: begin
        w_fu   = {1'b0, r_a[WIDTH-1:1]};
        w_fu_c = r_a[0];
      end
      4'd12: begin
        w_fu   = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
        w_fu_c = r_a[0];
      end
      4'd13: {w_fu_c, w_fu} = {1'b0, r_bp} - {1'b0, r_a};
      4'd14: {w_fu_c, w_fu} = {1'b0, r_a} + {1'b0, r_bp} + {{WIDTH{1'b0}}, r_flag_c};
      default: begin
        w_fu   = '0;
        w_fu_c = 1'b0;
      end
    endcase
  end

  assign w_res = r_data_sel ? r_data : w_fu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_ex_wr) begin
      r_regs[r_dest] <= w_res;
    end
  end

  // EX fields only load on issue so the EX outputs hold while the stage is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid <= 1'b0;
      r_load_en  <= 1'b0;
      r_data_sel <= 1'b0;
      r_dest     <= '0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_bp       <= '0;
      r_data     <= '0;
    end else begin
      r_ex_valid <= w_fire;
      if (w_fire) begin
        r_load_en  <= bus.load_en;
        r_data_sel <= bus.data_sel;
        r_dest     <= bus.dest_sel;
        r_op       <= bus.op_sel;
        r_a        <= w_rd_a;
        r_b        <= w_rd_b;
        r_bp       <= bus.const_sel ? bus.const_in : w_rd_b;
        r_data     <= bus.data_in;
      end
    end
  end

  // Flags track the FU result even when data_in is written back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (r_ex_valid) begin
      r_flag_z <= (w_fu == '0);
      r_flag_c <= w_fu_c;
      r_flag_n <= w_fu[WIDTH-1];
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_ex_valid;
  assign bus.a_out     = r_a;
  assign bus.b_out     = r_b;
  assign bus.around    = r_bp;
  assign bus.res_out   = w_res;
  assign bus.flag_z    = r_flag_z;
  assign bus.flag_c    = r_flag_c;
  assign bus.flag_n    = r_flag_n;
endmodule
